dmem_arbiter: RTL and testbench

//  Shares the byte-addressable data memory (combinational 4-byte little-endian read, 1-cycle write) between two requesters.

---
 rtl/dmem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin data-memory arbiter with read-modify-write sequencing for SB/SH stores.
// Optional misaligned-access flagging is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_arbiter #(
    parameter int WIDTH = 32,
    parameter int AW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic             we0_i,
    input  logic             we1_i,
    input  logic [1:0]       size0_i,
    input  logic [1:0]       size1_i,
    input  logic             uns0_i,
    input  logic             uns1_i,
    input  logic [AW-1:0]    addr0_i,
    input  logic [AW-1:0]    addr1_i,
    input  logic [WIDTH-1:0] wdata0_i,
    input  logic [WIDTH-1:0] wdata1_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             rvalid0_o,
    output logic             rvalid1_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic             err_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    output logic             mem_we_o,
    input  logic [WIDTH-1:0] mem_rdata_i
);

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

    state_t           state_q;
    logic             rr_last_q;
    logic             port_q;
    logic             we_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             mis_q;
    logic [AW-1:0]    mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic             mem_we_q;
    logic             rvalid0_q;
    logic             rvalid1_q;
    logic [WIDTH-1:0] rdata_q;
    logic             err_q;

    logic             gnt0;
    logic             gnt1;
    logic             g_we;
    logic [1:0]       g_size;
    logic             g_uns;
    logic [AW-1:0]    g_addr;
    logic [WIDTH-1:0] g_wdata;
    logic             g_mis;

    function automatic logic [WIDTH-1:0] extend(input logic [WIDTH-1:0] d,
                                                input logic [1:0] sz, input logic uns);
        logic [WIDTH-1:0] r;
        case (sz)
            SZ_BYTE: r = {{(WIDTH-8){~uns & d[7]}}, d[7:0]};
            SZ_HALF: r = {{(WIDTH-16){~uns & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                               input logic [WIDTH-1:0] nw, input logic [1:0] sz);
        logic [WIDTH-1:0] r;
        case (sz)
            SZ_BYTE: r = {old[WIDTH-1:8], nw[7:0]};
            SZ_HALF: r = {old[WIDTH-1:16], nw[15:0]};
            default: r = nw;
        endcase
        return r;
    endfunction

    // rr_last_q names the port that won the previous tie, so the other one wins the next.
    always_comb begin
        gnt0 = rst_n && (state_q == IDLE) && req0_i && (!req1_i || rr_last_q);
        gnt1 = rst_n && (state_q == IDLE) && req1_i && (!req0_i || !rr_last_q);
    end

    always_comb begin
        g_we    = gnt1 ? we1_i    : we0_i;
        g_size  = gnt1 ? size1_i  : size0_i;
        g_uns   = gnt1 ? uns1_i   : uns0_i;
        g_addr  = gnt1 ? addr1_i  : addr0_i;
        g_wdata = gnt1 ? wdata1_i : wdata0_i;
        g_mis   = ALIGN_CHK && (((g_size == SZ_HALF) && g_addr[0]) ||
                                (g_size[1] && (g_addr[1:0] != 2'b00)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_last_q   <= 1'b1;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            mis_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            mem_we_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        port_q      <= gnt1;
                        we_q        <= g_we;
                        size_q      <= g_size;
                        uns_q       <= g_uns;
                        mis_q       <= g_mis;
                        mem_addr_q  <= g_addr;
                        mem_wdata_q <= g_wdata;
                        // Full-word stores write during EXEC; sub-word ones wait for the merge.
                        mem_we_q    <= g_we && g_size[1] && !g_mis;
                        if (req0_i && req1_i) begin
                            rr_last_q <= gnt1;
                        end
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (we_q && !size_q[1] && !mis_q) begin
                        mem_wdata_q <= merge(mem_rdata_i, mem_wdata_q, size_q);
                        mem_we_q    <= 1'b1;
                        state_q     <= WRITE;
                    end else begin
                        if (!we_q && !mis_q) begin
                            rdata_q <= extend(mem_rdata_i, size_q, uns_q);
                        end
                        rvalid0_q <= !port_q;
                        rvalid1_q <= port_q;
                        err_q     <= mis_q;
                        state_q   <= IDLE;
                    end
                end
                WRITE: begin
                    rvalid0_q <= !port_q;
                    rvalid1_q <= port_q;
                    err_q     <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0_o      = gnt0;
    assign gnt1_o      = gnt1;
    assign rvalid0_o   = rvalid0_q;
    assign rvalid1_o   = rvalid1_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed loads, stores, RMW, ties and reset abort.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we, uns;
    logic [1:0]  size [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic        gnt0, gnt1, rvalid0, rvalid1, err, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic [7:0]  mem [256];
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          we_cnt = 0;
    int          last_we = -1;
    int          gnt_order [$];

    typedef struct {
        logic        port;
        bit          chk_rd;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb [$];

    dmem_arbiter #(.WIDTH(32), .AW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req[0]), .req1_i(req[1]), .we0_i(we[0]), .we1_i(we[1]),
        .size0_i(size[0]), .size1_i(size[1]), .uns0_i(uns[0]), .uns1_i(uns[1]),
        .addr0_i(addr[0]), .addr1_i(addr[1]), .wdata0_i(wdata[0]), .wdata1_i(wdata[1]),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
        .rdata_o(rdata), .err_o(err), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_we_o(mem_we), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Byte-indexed memory: combinational 4-byte little-endian read, word write on the clock.
    always_comb begin
        logic [7:0] a;
        a = mem_addr[7:0];
        mem_rdata = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    end

    always @(posedge clk) begin
        if (mem_we) begin
            logic [7:0] a;
            a = mem_addr[7:0];
            mem[a]         <= mem_wdata[7:0];
            mem[a + 8'd1]  <= mem_wdata[15:8];
            mem[a + 8'd2]  <= mem_wdata[23:16];
            mem[a + 8'd3]  <= mem_wdata[31:24];
        end
    end

    function automatic logic [31:0] rd_word(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops one expectation per completion pulse.
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            last_we = cyc;
        end
        if (rst_n && (rvalid0 || rvalid1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {rvalid1, rvalid0}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rvalid_port", {rvalid1, rvalid0}, e.port ? 32'd2 : 32'd1);
                chk("rvalid_cycle", cyc, e.cyc);
                chk("err", {31'd0, err}, {31'd0, e.err});
                if (e.chk_rd) chk("rdata", rdata, e.rd);
            end
        end
    end

    task automatic issue(input int p, input bit w, input logic [1:0] sz, input bit u,
                         input logic [31:0] a, input logic [31:0] wd, input bit chk_rd,
                         input logic [31:0] exp_rd, input bit exp_err, input int lat,
                         output int t);
        exp_t e;
        bit   got;
        got = 0;
        t   = -1;
        @(negedge clk);
        req[p] = 1'b1; we[p] = w; size[p] = sz; uns[p] = u; addr[p] = a; wdata[p] = wd;
        for (int i = 0; i < 30 && !got; i++) begin
            #1;
            if ((p == 0 && gnt0) || (p == 1 && gnt1)) begin
                got = 1;
                t   = cyc;
                gnt_order.push_back(p);
                e.port = (p == 1); e.chk_rd = chk_rd; e.rd = exp_rd;
                e.err = exp_err; e.cyc = cyc + lat;
                sb.push_back(e);
            end else begin
                @(negedge clk);
            end
        end
        chk("grant_seen", {31'd0, got}, 32'd1);
        if (got) @(posedge clk);
        #1 req[p] = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, t2, w0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'h3412FF80;
        {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} = 32'hAABBCCDD;
        {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]} = 32'h11223344;
        req = 2'b00; we = 2'b00; uns = 2'b00;
        size[0] = 2'b10; size[1] = 2'b10;
        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

        // Reset values, with a request pending to show grant is held off.
        rst_n = 1'b0;
        req[0] = 1'b1;
        #12;
        chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
        chk("rst_rvalid", {rvalid1, rvalid0}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Loads with sign and zero extension.
        issue(0, 0, 2'b00, 0, 32'h10, 32'h0, 1, 32'hFFFFFF80, 0, 2, t); wait_done();
        issue(0, 0, 2'b00, 1, 32'h10, 32'h0, 1, 32'h00000080, 0, 2, t); wait_done();
        issue(1, 0, 2'b01, 0, 32'h10, 32'h0, 1, 32'hFFFFFF80, 0, 2, t); wait_done();
        issue(1, 0, 2'b01, 1, 32'h10, 32'h0, 1, 32'h0000FF80, 0, 2, t); wait_done();
        issue(0, 0, 2'b01, 0, 32'h12, 32'h0, 1, 32'h00003412, 0, 2, t); wait_done();

        // Half-word RMW store from port 1.
        w0 = we_cnt;
        issue(1, 1, 2'b01, 0, 32'h20, 32'h00001234, 0, 32'h0, 0, 3, t); wait_done();
        chk("rmw_we_count", we_cnt - w0, 32'd1);
        chk("rmw_we_cycle", last_we, t + 2);
        chk("rmw_word", rd_word(8'h20), 32'hAABB1234);

        // Word store then load, then rdata holds across a store.
        w0 = we_cnt;
        issue(0, 1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 0, 32'h0, 0, 2, t); wait_done();
        chk("sw_we_count", we_cnt - w0, 32'd1);
        chk("sw_we_cycle", last_we, t + 1);
        issue(0, 0, 2'b10, 0, 32'h08, 32'h0, 1, 32'hDEADBEEF, 0, 2, t); wait_done();
        issue(1, 1, 2'b11, 0, 32'h40, 32'h01020304, 0, 32'h0, 0, 2, t); wait_done();
        chk("rdata_hold", rdata, 32'hDEADBEEF);
        chk("size11_word", rd_word(8'h40), 32'h01020304);

        // Misaligned accesses.
        w0 = we_cnt;
`ifdef DMEM_ALIGN_CHECK_EN
        issue(0, 0, 2'b10, 0, 32'h06, 32'h0, 1, 32'hDEADBEEF, 1, 2, t); wait_done();
        issue(0, 1, 2'b10, 0, 32'h02, 32'h0A0B0C0D, 0, 32'h0, 1, 2, t); wait_done();
        chk("mis_we_count", we_cnt - w0, 32'd0);
        chk("mis_word", rd_word(8'h02), 32'h00000000);
`else
        issue(0, 0, 2'b10, 0, 32'h06, 32'h0, 1, 32'hBEEF0000, 0, 2, t); wait_done();
        issue(0, 1, 2'b10, 0, 32'h02, 32'h0A0B0C0D, 0, 32'h0, 0, 2, t); wait_done();
        chk("mis_we_count", we_cnt - w0, 32'd1);
        chk("mis_word", rd_word(8'h02), 32'h0A0B0C0D);
`endif

        // Reset during the WRITE phase of a byte store aborts it.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; size[0] = 2'b00; addr[0] = 32'h30; wdata[0] = 32'h000000AA;
        #1 chk("abort_gnt", {31'd0, gnt0}, 32'd1);
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(posedge clk);
        #1 chk("abort_we_in_write", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1 chk("abort_we_drop", {31'd0, mem_we}, 32'd0);
        chk("abort_rvalid", {rvalid1, rvalid0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_mem_kept", rd_word(8'h30), 32'h11223344);
        issue(0, 1, 2'b00, 0, 32'h30, 32'h000000AA, 0, 32'h0, 0, 3, t); wait_done();
        chk("abort_reissue", rd_word(8'h30), 32'h112233AA);

        // Tie: both ports hold requests; grants alternate starting with port 0.
        gnt_order.delete();
        fork
            begin
                issue(0, 1, 2'b10, 0, 32'h50, 32'h00000050, 0, 32'h0, 0, 2, t);
                issue(0, 1, 2'b10, 0, 32'h54, 32'h00000054, 0, 32'h0, 0, 2, t);
            end
            begin
                issue(1, 1, 2'b10, 0, 32'h58, 32'h00000058, 0, 32'h0, 0, 2, t2);
                issue(1, 1, 2'b10, 0, 32'h5C, 32'h0000005C, 0, 32'h0, 0, 2, t2);
            end
        join
        wait_done();
        chk("tie_count", gnt_order.size(), 32'd4);
        for (int i = 0; i < 4 && i < gnt_order.size(); i++)
            chk("tie_order", gnt_order[i], i % 2);
        chk("tie_mem50", rd_word(8'h50), 32'h00000050);
        chk("tie_mem5c", rd_word(8'h5C), 32'h0000005C);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
